// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round helper functions.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SCHED_N = 16;
  localparam int unsigned ROUNDS  = 64;
  localparam int unsigned CNT_W   = 6;

  typedef logic [WORD_W-1:0] word_t;

  // Word 0 is the most significant word (big-endian order).
  typedef logic [0:SCHED_N-1][WORD_W-1:0] block_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam word_t K [0:ROUNDS-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam work_t IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Per-word modulo-2^32 addition of two hash states.
  function automatic work_t hash_add(input work_t x, input work_t y);
    return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d,
             e: x.e + y.e, f: x.f + y.f, g: x.g + y.g, h: x.h + y.h};
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-in / digest-out handshake bundle for sha256_compress.
// SHA256_CHAIN_EN swaps hash_in for the first flag.
interface sha256_compress_if
  import sha256_pkg::*;
;
  logic   in_valid;
  logic   in_ready;
  block_t block_in;
`ifdef SHA256_CHAIN_EN
  logic   first;
`else
  work_t  hash_in;
`endif
  logic   out_valid;
  logic   out_ready;
  work_t  digest;

`ifdef SHA256_CHAIN_EN
  modport master (output in_valid, block_in, first, out_ready,
                  input  in_ready, out_valid, digest);
  modport slave  (input  in_valid, block_in, first, out_ready,
                  output in_ready, out_valid, digest);
`else
  modport master (output in_valid, block_in, hash_in, out_ready,
                  input  in_ready, out_valid, digest);
  modport slave  (input  in_valid, block_in, hash_in, out_ready,
                  output in_ready, out_valid, digest);
`endif
endinterface

// File: rtl/sha256_rotr.sv
// Fixed-distance 32-bit rotate-right primitive.
module sha256_rotr
  import sha256_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  word_t x,
  output word_t y
);
  assign y = {x[N-1:0], x[WORD_W-1:N]};
endmodule

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h, K[t], W[t] -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t cur,
  input  word_t k,
  input  word_t w,
  output work_t nxt
);
  word_t r6, r11, r25;
  word_t s1, t1, t2;

  sha256_rotr #(.N(6))  u_rotr6  (.x(cur.e), .y(r6));
  sha256_rotr #(.N(11)) u_rotr11 (.x(cur.e), .y(r11));
  sha256_rotr #(.N(25)) u_rotr25 (.x(cur.e), .y(r25));

  assign s1 = r6 ^ r11 ^ r25;
  assign t1 = cur.h + s1 + ch(cur.e, cur.f, cur.g) + k + w;
  assign t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

  assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                 e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression engine, one round per clock.
// Define SHA256_CHAIN_EN to keep the chaining value internally (first flag instead of hash_in).
module sha256_compress
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  sha256_compress_if.slave   bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  block_t            win_q;
  work_t             work_q, hinit_q, digest_q;
  work_t             work_nxt, digest_nxt, h_sel;
  word_t             w_tail;
  logic              accept, last;

`ifdef SHA256_CHAIN_EN
  work_t chain_q;
  assign h_sel = bus.first ? IV : chain_q;
`else
  assign h_sel = bus.hash_in;
`endif

  sha256_round u_round (
    .cur (work_q),
    .k   (K[cnt_q]),
    .w   (win_q[0]),
    .nxt (work_nxt)
  );

  assign w_tail     = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
  assign digest_nxt = hash_add(hinit_q, work_nxt);
  assign bus.digest = digest_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs depend on the state register alone.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    last          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working variables, message schedule window and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      win_q    <= '0;
      work_q   <= '0;
      hinit_q  <= '0;
      digest_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      win_q   <= bus.block_in;
      work_q  <= h_sel;
      hinit_q <= h_sel;
    end else if (state_q == ROUND) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      win_q  <= {win_q[1:SCHED_N-1], w_tail};
      work_q <= work_nxt;
      if (last) digest_q <= digest_nxt;
    end
  end

`ifdef SHA256_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    chain_q <= IV;
    else if (last) chain_q <= digest_nxt;
  end
`endif

endmodule

// File: tb/tb_sha256_compress.sv
// Scoreboard bench for sha256_compress: known-answer digests, latency, backpressure, reset, streaming.
module tb_sha256_compress;
  import sha256_pkg::*;

  localparam logic [255:0] IV_H =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] BLK_ABC =
    512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] BLK_EMPTY =
    512'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [511:0] BLK_TWO1 =
    512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [255:0] H_TWO1 =
    256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [511:0] BLK_TWO2 =
    512'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_000001c0;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_compress_if bus ();

  sha256_compress dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  logic [255:0] exp_q [$];
  int unsigned  acc_q [$];
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drives a block; the chain build derives first from whether the chaining value is the IV.
  task automatic drive_in(input logic [511:0] blk, input logic [255:0] h);
    bus.block_in = blk;
`ifdef SHA256_CHAIN_EN
    bus.first = (h == IV_H);
`else
    bus.hash_in = h;
`endif
  endtask

  task automatic send(input logic [511:0] blk, input logic [255:0] h,
                      input logic [255:0] want, input bit hold);
    int n = 0;
    @(negedge clk);
    drive_in(blk, h);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 256'd0, 256'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(want);
    acc_q.push_back(cyc);
    last_acc = cyc;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !bus.in_ready) check("drain_timeout", 256'd0, 256'd1);
  endtask

  // Scoreboard: latency on out_valid rise, digest on each handshake.
  always @(negedge clk) begin
    if (bus.out_valid && !prev_ov) begin
      if (acc_q.size() == 0) check("latency_noacc", 256'd0, 256'd1);
      else                   check("latency", 256'(cyc - acc_q.pop_front()), 256'd64);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_digest", bus.digest, 256'd0 - 256'd1);
      else                   check("digest", bus.digest, exp_q.pop_front());
    end
    prev_ov = bus.out_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev_acc;
    int n;
    logic seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_in('0, IV_H);

    #12;
    check("rst_in_ready",  256'(bus.in_ready),  256'd1);
    check("rst_out_valid", 256'(bus.out_valid), 256'd0);
    check("rst_digest",    bus.digest,          256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(BLK_ABC, IV_H, D_ABC, 1'b0);
    wait_idle();
    send(BLK_EMPTY, IV_H, D_EMPTY, 1'b0);
    wait_idle();
    send(BLK_TWO1, IV_H, H_TWO1, 1'b0);
    send(BLK_TWO2, H_TWO1, D_TWO, 1'b0);
    wait_idle();

    // Backpressure: hold DONE for 10 cycles and poke in_valid meanwhile.
    bus.out_ready = 1'b0;
    send(BLK_ABC, IV_H, D_ABC, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 256'(bus.out_valid), 256'd1);
      check("bp_in_ready",  256'(bus.in_ready),  256'd0);
      check("bp_digest",    bus.digest,          D_ABC);
      if (i == 3) begin
        drive_in(BLK_EMPTY, IV_H);
        bus.in_valid = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    wait_idle();
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("bp_pulse_ignored", 256'(seen), 256'd0);

    // Reset in the middle of the round sequence.
    @(negedge clk);
    drive_in(BLK_EMPTY, IV_H);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  256'(bus.in_ready),  256'd1);
    check("midrst_out_valid", 256'(bus.out_valid), 256'd0);
    check("midrst_digest",    bus.digest,          256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(BLK_ABC, IV_H, D_ABC, 1'b0);
    wait_idle();

    // Streaming with in_valid and out_ready held high.
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      send(BLK_ABC, IV_H, D_ABC, 1'b1);
      if (k > 0) check("b2b_period", 256'(last_acc - prev_acc), 256'd66);
      prev_acc = last_acc;
    end
    bus.in_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
